uart_display_ctrl: RTL and testbench

//  Sits between uart_rx and the 8-digit SSD scanner. It owns the digit buffer and
//  a write cursor, and edits that buffer from received bytes (write, backspace, clear).

---
 rtl/uart_display_ctrl_pkg.sv | 22 ++
 rtl/uart_display_ctrl_echo_fifo.sv | 48 ++++
 rtl/uart_display_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_display_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_display_ctrl_pkg.sv
// Shared constants, TX handshake states and byte classification used by the
// UART-driven display controller and its echo FIFO.
package uart_display_ctrl_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} tx_state_t;

  typedef enum logic [1:0] {CMD_IGNORE, CMD_CHAR, CMD_BS, CMD_CR} rx_cmd_t;

  function automatic rx_cmd_t decode_byte(input logic [7:0] b);
    if (b >= CH_PRINT_LO && b <= CH_PRINT_HI) return CMD_CHAR;
    if (b == CH_BS) return CMD_BS;
    if (b == CH_CR) return CMD_CR;
    return CMD_IGNORE;
  endfunction

endpackage

// File: rtl/uart_display_ctrl_echo_fifo.sv
// Small synchronous FIFO buffering echo bytes between the RX decoder and the
// slower TX handshake. A push on a full FIFO succeeds only if a pop happens too.
module echo_fifo
  import uart_display_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_display_ctrl.sv
// Owns the SSD character buffer and write cursor, edits them from received
// UART bytes, and echoes accepted bytes back through the uart_tx handshake.
module uart_display_ctrl
  import uart_display_ctrl_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit SCROLL     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        tx_ready,
  output logic                        tx_send,
  output logic [7:0]                  tx_data,
  output logic [8*N_DIGITS-1:0]       digits,
  output logic [$clog2(N_DIGITS)-1:0] cursor,
  output logic                        echo_drop
);

  localparam int CW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

  logic [7:0]    disp   [N_DIGITS];
  logic [7:0]    disp_n [N_DIGITS];
  logic [CW-1:0] cursor_n;
  logic          last_full;
  logic          last_full_n;
  logic          accept;
  rx_cmd_t       cmd;

  tx_state_t     state;
  tx_state_t     state_n;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  assign cmd = decode_byte(rx_data);

  // In scroll mode the cursor parks on the last digit; last_full records that
  // this digit already holds a character, so only later writes shift the row.
  always_comb begin
    disp_n      = disp;
    cursor_n    = cursor;
    last_full_n = last_full;
    accept      = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_CHAR: begin
          accept = 1'b1;
          if (cursor != LAST) begin
            disp_n[cursor] = rx_data;
            cursor_n       = cursor + 1'b1;
          end else if (SCROLL) begin
            if (last_full) begin
              for (int i = 0; i < N_DIGITS - 1; i++) disp_n[i] = disp[i+1];
            end
            disp_n[LAST] = rx_data;
            last_full_n  = 1'b1;
          end else begin
            disp_n[LAST] = rx_data;
            cursor_n     = '0;
          end
        end
        CMD_BS: begin
          accept      = 1'b1;
          last_full_n = 1'b0;
          if (cursor != '0) begin
            cursor_n                 = cursor - 1'b1;
            disp_n[cursor - 1'b1]    = CH_SPACE;
          end
        end
        CMD_CR: begin
          accept      = 1'b1;
          last_full_n = 1'b0;
          cursor_n    = '0;
          for (int i = 0; i < N_DIGITS; i++) disp_n[i] = CH_SPACE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < N_DIGITS; i++) disp[i] <= CH_SPACE;
      cursor    <= '0;
      last_full <= 1'b0;
    end else begin
      disp      <= disp_n;
      cursor    <= cursor_n;
      last_full <= last_full_n;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digits
    assign digits[8*g +: 8] = disp[g];
  end

  echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_echo_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (accept),
    .pop     (pop),
    .wr_data (rx_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // One byte in flight: pop only from IDLE, then follow tx_ready low and high again.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && tx_ready) begin
          pop     = 1'b1;
          state_n = SEND;
        end
      end
      SEND:      state_n = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_n = WAIT_DONE;
      WAIT_DONE: if (tx_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign tx_send = (state == SEND);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      echo_drop <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) tx_data <= fifo_head;
      if (accept && fifo_full && !pop) echo_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_display_ctrl.sv
// Directed and random bench for uart_display_ctrl: a scrolling and a wrapping
// instance share the RX stream and are checked against a byte-level model.
module tb_uart_display_ctrl;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        tx_busy;
  logic        hold_tx;

  logic        tx_send_s, tx_send_w;
  logic [7:0]  tx_data_s, tx_data_w;
  logic [63:0] digits_s, digits_w;
  logic [2:0]  cursor_s, cursor_w;
  logic        echo_drop_s, echo_drop_w;

  int total = 0;
  int bad   = 0;
  int send_count = 0;

  logic [7:0] got_q [$];
  logic [7:0] got_w [$];
  logic [7:0] exp_q [$];

  logic [7:0] m_disp [2][N];
  int         m_cur  [2];
  bit         m_full;
  bit         m_drop;
  int         held_cnt;

  assign tx_ready = !tx_busy && !hold_tx;

  uart_display_ctrl #(.N_DIGITS(N), .FIFO_DEPTH(DEPTH), .SCROLL(1'b1)) dut_s (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_send(tx_send_s), .tx_data(tx_data_s), .digits(digits_s), .cursor(cursor_s),
    .echo_drop(echo_drop_s)
  );

  uart_display_ctrl #(.N_DIGITS(N), .FIFO_DEPTH(DEPTH), .SCROLL(1'b0)) dut_w (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_send(tx_send_w), .tx_data(tx_data_w), .digits(digits_w), .cursor(cursor_w),
    .echo_drop(echo_drop_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: takes the byte on tx_send and stays busy for three cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send_s === 1'b1) begin
        got_q.push_back(tx_data_s);
        send_count++;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_send_w === 1'b1) got_w.push_back(tx_data_w);
  end

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) m_disp[k][i] = 8'h20;
      m_cur[k] = 0;
    end
    m_full   = 1'b0;
    m_drop   = 1'b0;
    held_cnt = 0;
  endfunction

  // k=0 is the scrolling display, k=1 the wrapping one.
  function automatic bit model_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (b >= 8'h20 && b <= 8'h7E) begin
        acc = 1'b1;
        if (m_cur[k] < N - 1) begin
          m_disp[k][m_cur[k]] = b;
          m_cur[k]++;
        end else if (k == 0) begin
          if (m_full) for (int i = 0; i < N - 1; i++) m_disp[0][i] = m_disp[0][i+1];
          m_disp[0][N-1] = b;
          m_full = 1'b1;
        end else begin
          m_disp[1][N-1] = b;
          m_cur[1] = 0;
        end
      end else if (b == 8'h08) begin
        acc = 1'b1;
        if (k == 0) m_full = 1'b0;
        if (m_cur[k] > 0) begin
          m_cur[k]--;
          m_disp[k][m_cur[k]] = 8'h20;
        end
      end else if (b == 8'h0D) begin
        acc = 1'b1;
        if (k == 0) m_full = 1'b0;
        for (int i = 0; i < N; i++) m_disp[k][i] = 8'h20;
        m_cur[k] = 0;
      end
    end
    return acc;
  endfunction

  function automatic logic [63:0] model_digits(input int k);
    logic [63:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = m_disp[k][i];
    return r;
  endfunction

  function automatic logic [63:0] str_digits(input string s);
    logic [63:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = (i < s.len()) ? s.getc(i) : 8'h20;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one byte for a single cycle; consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    if (model_byte(b)) begin
      if (hold_tx) begin
        if (held_cnt < DEPTH) begin
          exp_q.push_back(b);
          held_cnt++;
        end else begin
          m_drop = 1'b1;
        end
      end else begin
        exp_q.push_back(b);
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s.getc(i));
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    @(negedge clk);
    checkOutput({tag, " digits_s"}, digits_s, model_digits(0));
    checkOutput({tag, " cursor_s"}, 64'(cursor_s), 64'(m_cur[0]));
    checkOutput({tag, " digits_w"}, digits_w, model_digits(1));
    checkOutput({tag, " cursor_w"}, 64'(cursor_w), 64'(m_cur[1]));
    checkOutput({tag, " drop_s"}, 64'(echo_drop_s), 64'(m_drop));
    checkOutput({tag, " drop_w"}, 64'(echo_drop_w), 64'(m_drop));
  endtask

  task automatic drain_echo(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() >= exp_q.size() && got_w.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    idle(20);
    checkOutput({tag, " echo count"}, 64'(got_q.size()), 64'(exp_q.size()));
    checkOutput({tag, " echo count w"}, 64'(got_w.size()), 64'(exp_q.size()));
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) checkOutput({tag, " echo byte"}, 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    got_w.delete();
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    logic [7:0] b;
    int r;

    rstn = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; hold_tx = 1'b0;
    model_reset();
    idle(3);
    checkOutput("reset digits", digits_s, 64'h2020202020202020);
    checkOutput("reset cursor", 64'(cursor_s), 64'd0);
    checkOutput("reset tx_send", 64'(tx_send_s), 64'd0);
    checkOutput("reset tx_data", 64'(tx_data_s), 64'd0);
    checkOutput("reset drop", 64'(echo_drop_s), 64'd0);
    rstn = 1'b0;
    idle(2);

    $display("[TB] HELLO back-to-back");
    send_str("HELLO", 0);
    check_display("hello");
    checkOutput("hello text", digits_s, str_digits("HELLO"));
    checkOutput("hello cursor", 64'(cursor_s), 64'd5);
    drain_echo("hello");

    $display("[TB] scroll and wrap");
    applyStimulus(8'h0D);
    drain_echo("clear");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h41 + 8'(i));
      idle(9);
      if (i == 8) begin
        checkOutput("wrap digit0", 64'(digits_w[7:0]), 64'h49);
        checkOutput("wrap cursor", 64'(cursor_w), 64'd1);
      end
    end
    check_display("scroll");
    checkOutput("scroll text", digits_s, str_digits("CDEFGHIJ"));
    checkOutput("scroll cursor", 64'(cursor_s), 64'd7);
    drain_echo("scroll");

    $display("[TB] backspace");
    applyStimulus(8'h0D);
    drain_echo("clear2");
    applyStimulus(8'h41); applyStimulus(8'h42);
    applyStimulus(8'h08); applyStimulus(8'h08); applyStimulus(8'h08);
    check_display("bs");
    checkOutput("bs text", digits_s, 64'h2020202020202020);
    checkOutput("bs cursor", 64'(cursor_s), 64'd0);
    drain_echo("bs");

    $display("[TB] echo overflow");
    hold_tx = 1'b1; held_cnt = 0;
    send_str("123456", 0);
    check_display("overflow");
    checkOutput("overflow drop", 64'(echo_drop_s), 64'd1);
    checkOutput("overflow text", digits_s, str_digits("123456"));
    hold_tx = 1'b0;
    drain_echo("overflow");

    $display("[TB] carriage return and ignored code");
    send_str("XYZ", 0);
    applyStimulus(8'h0D);
    check_display("cr");
    checkOutput("cr text", digits_s, 64'h2020202020202020);
    drain_echo("cr");
    cnt = send_count;
    applyStimulus(8'h07);
    idle(20);
    check_display("ignored");
    checkOutput("ignored no send", 64'(send_count), 64'(cnt));
    drain_echo("ignored");

    $display("[TB] random bytes");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      b = 8'($urandom_range(32, 126));
      else if (r < 15) b = 8'h08;
      else if (r < 16) b = 8'h0D;
      else begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h08 || b == 8'h0D) b = 8'h7F;
      end
      applyStimulus(b);
      idle(9);
      check_display("random");
    end
    drain_echo("random");

    $display("[TB] reset during transfer");
    cnt = send_count;
    applyStimulus(8'h51); applyStimulus(8'h52);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (send_count > cnt) break;
    end
    checkOutput("mid send seen", 64'(send_count > cnt), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    checkOutput("mid tx_send", 64'(tx_send_s), 64'd0);
    checkOutput("mid tx_data", 64'(tx_data_s), 64'd0);
    checkOutput("mid digits", digits_s, 64'h2020202020202020);
    checkOutput("mid cursor", 64'(cursor_s), 64'd0);
    checkOutput("mid drop", 64'(echo_drop_s), 64'd0);
    model_reset();
    exp_q.delete();
    got_q.delete();
    got_w.delete();
    @(posedge clk);
    #1 rstn = 1'b0;
    cnt = send_count;
    idle(30);
    checkOutput("post reset no send", 64'(send_count), 64'(cnt));
    applyStimulus(8'h5A);
    check_display("post reset");
    drain_echo("post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
